// File: rtl/sin_table_loader.sv
// Sine-table writer: assembles {low,high} byte pairs into 16-bit BRAM writes and verifies a trailing XOR checksum.
// Latency: bram_we asserts the cycle after the high byte is accepted; load_done/table_valid follow the checksum byte by one cycle.
// Backpressure: in_ready is low only in DONE and during reset. SIN_LOADER_TIMEOUT_EN adds an inter-byte timeout.
module sin_table_loader #(
    parameter int          SINBITS        = 16,
    parameter int          SINSAMPLES     = 256,
    parameter int          SINSAMPLEBITS  = 8,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic                     bram_clk,
    input  logic                     bram_rst,
    input  logic [7:0]               IN_BYTE,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [SINSAMPLEBITS-1:0] BRAM_WADDR,
    output logic [SINBITS-1:0]       BRAM_WDATA,
    output logic                     bram_we,
    output logic                     load_busy,
    output logic                     load_done,
    output logic                     load_err,
    output logic                     table_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_CSUM,
        S_DONE
    } state_t;

    localparam logic [SINSAMPLEBITS-1:0] LAST_ADDR = SINSAMPLEBITS'(SINSAMPLES - 1);

    state_t                   state_q, state_d;
    logic [SINSAMPLEBITS-1:0] addr_q, addr_d;
    logic [SINSAMPLEBITS-1:0] waddr_q, waddr_d;
    logic [SINBITS-1:0]       wdata_q, wdata_d;
    logic [7:0]               low_q, low_d;
    logic [7:0]               csum_q, csum_d;
    logic                     we_q, we_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic                     valid_q, valid_d;
    logic                     accept;
    logic                     in_frame;
    logic                     tmo_hit;

    assign in_ready = !bram_rst && (state_q != S_DONE);
    assign accept   = in_valid && in_ready;
    assign in_frame = (state_q == S_LO) || (state_q == S_HI) || (state_q == S_CSUM);

`ifdef SIN_LOADER_TIMEOUT_EN
    localparam int TMO_BITS = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_BITS-1:0] tmo_q, tmo_d;

    // Counts idle cycles inside a frame; any accepted byte restarts the window.
    always_comb begin
        tmo_hit = 1'b0;
        tmo_d   = '0;
        if (in_frame && !accept) begin
            if (tmo_q == TMO_BITS'(TIMEOUT_CYCLES - 1)) begin
                tmo_hit = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_BITS'(1);
            end
        end
    end

    always_ff @(posedge bram_clk) begin
        if (bram_rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_timeout;

    assign tmo_hit        = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        low_d   = low_q;
        csum_d  = csum_q;
        busy_d  = busy_q;
        err_d   = err_q;
        valid_d = valid_q;
        we_d    = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept && (IN_BYTE == SYNC_BYTE)) begin
                    state_d = S_LO;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    addr_d  = '0;
                    csum_d  = '0;
                end
            end
            S_LO: begin
                if (accept) begin
                    low_d   = IN_BYTE;
                    csum_d  = csum_q ^ IN_BYTE;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (accept) begin
                    wdata_d = {IN_BYTE, low_q};
                    waddr_d = addr_q;
                    we_d    = 1'b1;
                    csum_d  = csum_q ^ IN_BYTE;
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_CSUM;
                    end else begin
                        addr_d  = addr_q + SINSAMPLEBITS'(1);
                        state_d = S_LO;
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (IN_BYTE == csum_q) begin
                        valid_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A stalled frame is abandoned; partial BRAM contents are left as written.
        if (tmo_hit) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge bram_clk) begin
        if (bram_rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            low_q   <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            low_q   <= low_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    assign BRAM_WADDR  = waddr_q;
    assign BRAM_WDATA  = wdata_q;
    assign bram_we     = we_q;
    assign load_busy   = busy_q;
    assign load_done   = done_q;
    assign load_err    = err_q;
    assign table_valid = valid_q;

endmodule
